// File: rtl/wb_arbiter_if.sv
// Write-back arbiter bus: pipeline write, long-latency result handshake,
// hazard lookup and the registered regfile write port.
interface wb_arbiter_if #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic              pipe_we;
  logic [ADDR_W-1:0] pipe_waddr;
  logic [DATA_W-1:0] pipe_wdata;
  logic              lu_valid;
  logic              lu_ready;
  logic [ADDR_W-1:0] lu_waddr;
  logic [DATA_W-1:0] lu_wdata;
  logic [ADDR_W-1:0] lk_addr;
  logic              lk_hit;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              stall_req;
  logic [CW-1:0]     fifo_cnt;

  modport master (
    output pipe_we, pipe_waddr, pipe_wdata, lu_valid, lu_waddr, lu_wdata, lk_addr,
    input  lu_ready, lk_hit, we, waddr, wdata, stall_req, fifo_cnt
  );

  modport slave (
    input  pipe_we, pipe_waddr, pipe_wdata, lu_valid, lu_waddr, lu_wdata, lk_addr,
    output lu_ready, lk_hit, we, waddr, wdata, stall_req, fifo_cnt
  );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: pipeline writes win, long-latency results queue in a FIFO
// and drain on idle cycles. Optional starvation guard: WB_STARVE_GUARD_EN.
module wb_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  wb_arbiter_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_param_chk
    $error("wb_arbiter: FIFO_DEPTH must be a power of two >= 2 and STARVE_LIMIT >= 1");
  end

  logic [ADDR_W-1:0] r_mem_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] r_mem_data [FIFO_DEPTH];
  logic [PW-1:0]     r_rd, r_wr;
  logic [CW-1:0]     r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;

  logic w_full, w_pipe_sel, w_pop, w_ready, w_push, w_lk_hit, w_starved;

  assign w_full     = (r_cnt == CW'(FIFO_DEPTH));
  assign w_pipe_sel = bus.pipe_we && (bus.pipe_waddr != '0);
  assign w_pop      = !w_pipe_sel && (r_cnt != '0);
  assign w_ready    = !w_full;
  // x0 results complete the handshake but never occupy an entry
  assign w_push     = bus.lu_valid && w_ready && (bus.lu_waddr != '0);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_wr] <= bus.lu_waddr;
      r_mem_data[r_wr] <= bus.lu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (w_pipe_sel) begin
      r_we    <= 1'b1;
      r_waddr <= bus.pipe_waddr;
      r_wdata <= bus.pipe_wdata;
    end else if (w_pop) begin
      r_we    <= 1'b1;
      r_waddr <= r_mem_addr[r_rd];
      r_wdata <= r_mem_data[r_rd];
    end else begin
      r_we    <= 1'b0;
    end
  end

  // An entry is live when its distance from the read pointer is below the count
  always_comb begin
    w_lk_hit = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (({1'b0, PW'(i) - r_rd} < r_cnt) && (r_mem_addr[i] == bus.lk_addr))
        w_lk_hit = 1'b1;
    end
    if (bus.lk_addr == '0) w_lk_hit = 1'b0;
  end

`ifdef WB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] r_starve;

  always_ff @(posedge clk) begin
    if (rst || w_pop || (r_cnt == '0))
      r_starve <= '0;
    else if (r_starve != SW'(STARVE_LIMIT))
      r_starve <= r_starve + 1'b1;
  end

  assign w_starved = (r_starve == SW'(STARVE_LIMIT));
`else
  assign w_starved = 1'b0;
`endif

  // Outputs are forced quiet for the whole reset window, not just after the first edge
  assign bus.lu_ready  = !rst && w_ready;
  assign bus.lk_hit    = !rst && w_lk_hit;
  assign bus.stall_req = !rst && (w_full || w_starved);
  assign bus.fifo_cnt  = rst ? '0 : r_cnt;
  assign bus.we        = !rst && r_we;
  assign bus.waddr     = rst ? '0 : r_waddr;
  assign bus.wdata     = rst ? '0 : r_wdata;
endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: stimulus queues expected regfile writes,
// a negedge monitor pops and compares every write the DUT presents.
module tb_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int FD = 4;
  localparam int SL = 8;
`ifdef WB_STARVE_GUARD_EN
  localparam logic GUARD = 1'b1;
`else
  localparam logic GUARD = 1'b0;
`endif

  typedef struct {
    int          c;
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tot = 0;
  int   n_bad = 0;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(FD)) bus ();

  wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(FD), .STARVE_LIMIT(SL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_tot++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, req);
    end
  endtask

  task automatic expect_wr(input int c, input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    e.c = c; e.a = a; e.d = d;
    sb.push_back(e);
  endtask

  task automatic pipe(input logic [4:0] a, input logic [31:0] d);
    bus.pipe_we    = 1'b1;
    bus.pipe_waddr = a;
    bus.pipe_wdata = d;
    if (a != 5'd0) expect_wr(cyc + 1, a, d);
  endtask

  task automatic lu(input logic [4:0] a, input logic [31:0] d);
    bus.lu_valid = 1'b1;
    bus.lu_waddr = a;
    bus.lu_wdata = d;
  endtask

  task automatic idle();
    bus.pipe_we    = 1'b0;
    bus.pipe_waddr = '0;
    bus.pipe_wdata = '0;
    bus.lu_valid   = 1'b0;
    bus.lu_waddr   = '0;
    bus.lu_wdata   = '0;
    bus.lk_addr    = '0;
  endtask

  always @(negedge clk) begin
    if (bus.we === 1'b1) begin
      n_tot++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL wr_unexpected cyc=%0d got=%0d/%h want=none", cyc, bus.waddr, bus.wdata);
      end else begin
        mon_e = sb.pop_front();
        if (cyc != mon_e.c || bus.waddr !== mon_e.a || bus.wdata !== mon_e.d) begin
          n_bad++;
          $display("FAIL wr_match got=cyc%0d %0d/%h want=cyc%0d %0d/%h",
                   cyc, bus.waddr, bus.wdata, mon_e.c, mon_e.a, mon_e.d);
        end
      end
    end
  end

  initial begin
    idle();
    // reset with random inputs
    for (int k = 0; k < 3; k++) begin
      bus.pipe_we    = 1'($urandom);
      bus.pipe_waddr = 5'($urandom);
      bus.pipe_wdata = $urandom;
      bus.lu_valid   = 1'($urandom);
      bus.lu_waddr   = 5'($urandom);
      bus.lu_wdata   = $urandom;
      bus.lk_addr    = 5'($urandom);
      @(negedge clk);
      chk("rst_we", 64'(bus.we), 64'd0);
      chk("rst_cnt", 64'(bus.fifo_cnt), 64'd0);
      chk("rst_ready", 64'(bus.lu_ready), 64'd0);
      chk("rst_stall", 64'(bus.stall_req), 64'd0);
    end
    idle();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_we", 64'(bus.we), 64'd0);
    chk("post_rst_ready", 64'(bus.lu_ready), 64'd1);
    chk("post_rst_cnt", 64'(bus.fifo_cnt), 64'd0);

    // pipe path, x0 drop, hold
    pipe(5'd5, 32'hDEADBEEF);
    @(negedge clk);
    pipe(5'd0, 32'h12345678);
    @(negedge clk);
    chk("x0_we", 64'(bus.we), 64'd0);
    chk("hold_waddr", 64'(bus.waddr), 64'd5);
    chk("hold_wdata", 64'(bus.wdata), 64'hDEADBEEF);
    pipe(5'd31, 32'hFFFFFFFF);
    @(negedge clk);
    idle();
    @(negedge clk);

    // drain order, minimum latency 2
    lu(5'd3, 32'h11);
    expect_wr(cyc + 2, 5'd3, 32'h11);
    @(negedge clk);
    lu(5'd4, 32'h22);
    expect_wr(cyc + 2, 5'd4, 32'h22);
    chk("drain_cnt1", 64'(bus.fifo_cnt), 64'd1);
    @(negedge clk);
    idle();
    chk("drain_pushpop_cnt", 64'(bus.fifo_cnt), 64'd1);
    @(negedge clk);
    chk("drain_cnt0", 64'(bus.fifo_cnt), 64'd0);
    @(negedge clk);

    // fill under pipe pressure, refuse while full, drain in order
    for (int k = 0; k < 4; k++) begin
      pipe(5'(20 + k), 32'h100 + k);
      lu(5'(12 + k), 32'hA0 + k);
      @(negedge clk);
    end
    chk("full_cnt", 64'(bus.fifo_cnt), 64'd4);
    chk("full_ready", 64'(bus.lu_ready), 64'd0);
    chk("full_stall", 64'(bus.stall_req), 64'd1);
    pipe(5'd24, 32'h104);
    lu(5'd16, 32'hBB);
    @(negedge clk);
    chk("full_hold_cnt", 64'(bus.fifo_cnt), 64'd4);
    chk("full_hold_ready", 64'(bus.lu_ready), 64'd0);
    bus.pipe_we = 1'b0;
    for (int k = 0; k < 4; k++) expect_wr(cyc + 1 + k, 5'(12 + k), 32'hA0 + k);
    expect_wr(cyc + 5, 5'd16, 32'hBB);
    @(negedge clk);
    chk("pop1_ready", 64'(bus.lu_ready), 64'd1);
    chk("pop1_cnt", 64'(bus.fifo_cnt), 64'd3);
    chk("pop1_stall", 64'(bus.stall_req), 64'd0);
    @(negedge clk);
    bus.lu_valid = 1'b0;
    chk("pop2_cnt", 64'(bus.fifo_cnt), 64'd3);
    repeat (4) @(negedge clk);
    chk("empty_cnt", 64'(bus.fifo_cnt), 64'd0);

    // hazard lookup
    pipe(5'd25, 32'h105);
    lu(5'd7, 32'h77);
    bus.lk_addr = 5'd7;
    @(negedge clk);
    chk("lk_hit7", 64'(bus.lk_hit), 64'd1);
    bus.lu_valid = 1'b0;
    pipe(5'd26, 32'h106);
    bus.lk_addr = 5'd0;
    @(negedge clk);
    chk("lk_x0", 64'(bus.lk_hit), 64'd0);
    pipe(5'd27, 32'h107);
    bus.lk_addr = 5'd8;
    @(negedge clk);
    chk("lk_miss8", 64'(bus.lk_hit), 64'd0);
    bus.pipe_we = 1'b0;
    bus.lk_addr = 5'd7;
    expect_wr(cyc + 1, 5'd7, 32'h77);
    #1;
    chk("lk_pop_cycle", 64'(bus.lk_hit), 64'd1);
    @(negedge clk);
    chk("lk_after_pop", 64'(bus.lk_hit), 64'd0);
    chk("lk_after_cnt", 64'(bus.fifo_cnt), 64'd0);
    idle();
    @(negedge clk);

    // starvation: one entry queued behind a continuous pipe stream
    pipe(5'd17, 32'h600);
    lu(5'd9, 32'h99);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      bus.lu_valid = 1'b0;
      if (k == 8) chk("starve_pre", 64'(bus.stall_req), 64'd0);
      if (k >= 9) chk("starve_stall", 64'(bus.stall_req), 64'(GUARD));
      if (k < 10) pipe(5'(17 + k), 32'h600 + k);
      else begin
        bus.pipe_we = 1'b0;
        expect_wr(cyc + 1, 5'd9, 32'h99);
      end
    end
    #1;
    chk("starve_pop_cycle", 64'(bus.stall_req), 64'(GUARD));
    @(negedge clk);
    chk("starve_clear", 64'(bus.stall_req), 64'd0);
    idle();
    @(negedge clk);

    // reset mid-drain discards queued entries
    for (int k = 0; k < 3; k++) begin
      pipe(5'(1 + k), 32'h700 + k);
      lu(5'(10 + k), 32'hB0 + k);
      @(negedge clk);
    end
    idle();
    expect_wr(cyc + 1, 5'd10, 32'hB0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_cnt", 64'(bus.fifo_cnt), 64'd0);
    chk("rst_mid_we", 64'(bus.we), 64'd0);
    rst = 1'b0;
    bus.lk_addr = 5'd11;
    @(negedge clk);
    chk("after_rst_we", 64'(bus.we), 64'd0);
    chk("after_rst_cnt", 64'(bus.fifo_cnt), 64'd0);
    chk("after_rst_lk", 64'(bus.lk_hit), 64'd0);
    chk("after_rst_ready", 64'(bus.lu_ready), 64'd1);
    repeat (4) @(negedge clk);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
